// File: rtl/decode_stage_hs.sv
// RV32I/M decode stage with valid/ready handshake and a main+skid output buffer.
// Decode is combinational from in_instr; payloads are held in two registered entries.
`ifndef ALU_WIDTH
`define ALU_WIDTH 14
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif

module decode_stage_hs #(
    parameter bit M_EXT     = 1'b1,
    parameter int CNT_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 in_instr,
    input  logic [31:0]                 in_pc,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 pc,
    output logic [4:0]                  rs1,
    output logic [4:0]                  rs2,
    output logic [4:0]                  rd,
    output logic [2:0]                  funct3,
    output logic [31:0]                 imm,
    output logic [`ALU_WIDTH-1:0]       alu_operation,
    output logic [`OPCODE_WIDTH-1:0]    opcode_type,
    output logic [7:0]                  mdu_op,
    output logic [`EXCEPTION_WIDTH-1:0] exception,
    output logic [CNT_WIDTH-1:0]        decoded_cnt,
    output logic [CNT_WIDTH-1:0]        illegal_cnt
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;
    localparam logic [3:0] ALU_NEQ  = 4'd11;
    localparam logic [3:0] ALU_GE   = 4'd12;
    localparam logic [3:0] ALU_GEU  = 4'd13;

    localparam int OPC_RTYPE  = 0;
    localparam int OPC_ITYPE  = 1;
    localparam int OPC_LOAD   = 2;
    localparam int OPC_STORE  = 3;
    localparam int OPC_BRANCH = 4;
    localparam int OPC_JAL    = 5;
    localparam int OPC_JALR   = 6;
    localparam int OPC_LUI    = 7;
    localparam int OPC_AUIPC  = 8;
    localparam int OPC_SYSTEM = 9;
    localparam int OPC_FENCE  = 10;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef struct packed {
        logic [31:0]                 pc;
        logic [4:0]                  rs1;
        logic [4:0]                  rs2;
        logic [4:0]                  rd;
        logic [2:0]                  funct3;
        logic [31:0]                 imm;
        logic [`ALU_WIDTH-1:0]       alu_operation;
        logic [`OPCODE_WIDTH-1:0]    opcode_type;
        logic [7:0]                  mdu_op;
        logic [`EXCEPTION_WIDTH-1:0] exception;
    } payload_t;

    function automatic logic [3:0] arith_sel(input logic [2:0] f, input logic alt);
        logic [3:0] s;
        case (f)
            3'b000:  s = alt ? ALU_SUB : ALU_ADD;
            3'b001:  s = ALU_SLL;
            3'b010:  s = ALU_SLT;
            3'b011:  s = ALU_SLTU;
            3'b100:  s = ALU_XOR;
            3'b101:  s = alt ? ALU_SRA : ALU_SRL;
            3'b110:  s = ALU_OR;
            default: s = ALU_AND;
        endcase
        return s;
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] sys;
    logic [31:0] imm_i;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign sys    = in_instr[31:20];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};

    payload_t   dec;
    logic       illegal;
    logic       m_op;
    logic       ecall;
    logic       ebreak;
    logic       mret;
    logic [3:0] alu_sel;

    always_comb begin
        dec        = '0;
        dec.pc     = in_pc;
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.rd     = in_instr[11:7];
        dec.funct3 = f3;
        illegal    = 1'b0;
        m_op       = 1'b0;
        ecall      = 1'b0;
        ebreak     = 1'b0;
        mret       = 1'b0;
        alu_sel    = ALU_ADD;
        unique case (opcode)
            OP_RTYPE: begin
                dec.opcode_type[OPC_RTYPE] = 1'b1;
                m_op    = M_EXT && (f7 == F7_MUL);
                alu_sel = arith_sel(f3, in_instr[30]);
                illegal = !((f7 == F7_BASE) || m_op ||
                            ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OP_ITYPE: begin
                dec.opcode_type[OPC_ITYPE] = 1'b1;
                dec.imm = imm_i;
                // addi has no subtract form; bit 30 only selects SRA
                alu_sel = (f3 == 3'b000) ? ALU_ADD : arith_sel(f3, in_instr[30]);
                illegal = ((f3 == 3'b001) && (f7 != F7_BASE)) ||
                          ((f3 == 3'b101) && (f7 != F7_BASE) && (f7 != F7_ALT));
            end
            OP_LOAD: begin
                dec.opcode_type[OPC_LOAD] = 1'b1;
                dec.imm = imm_i;
                illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_STORE: begin
                dec.opcode_type[OPC_STORE] = 1'b1;
                dec.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                illegal = (f3 >= 3'b011);
            end
            OP_BRANCH: begin
                dec.opcode_type[OPC_BRANCH] = 1'b1;
                dec.imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
                case (f3)
                    3'b000:  alu_sel = ALU_EQ;
                    3'b001:  alu_sel = ALU_NEQ;
                    3'b100:  alu_sel = ALU_SLT;
                    3'b101:  alu_sel = ALU_GE;
                    3'b110:  alu_sel = ALU_SLTU;
                    3'b111:  alu_sel = ALU_GEU;
                    default: illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                dec.opcode_type[OPC_JAL] = 1'b1;
                dec.imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            end
            OP_JALR: begin
                dec.opcode_type[OPC_JALR] = 1'b1;
                dec.imm = imm_i;
                illegal = (f3 != 3'b000);
            end
            OP_LUI: begin
                dec.opcode_type[OPC_LUI] = 1'b1;
                dec.imm = {in_instr[31:12], 12'd0};
            end
            OP_AUIPC: begin
                dec.opcode_type[OPC_AUIPC] = 1'b1;
                dec.imm = {in_instr[31:12], 12'd0};
            end
            OP_SYSTEM: begin
                dec.opcode_type[OPC_SYSTEM] = 1'b1;
                dec.imm = {20'd0, sys};
                if (f3 == 3'b100) begin
                    illegal = 1'b1;
                end else if (f3 == 3'b000) begin
                    ecall   = (sys == 12'h000);
                    ebreak  = (sys == 12'h001);
                    mret    = (sys == 12'h302);
                    illegal = !(ecall || ebreak || mret || (sys == 12'h105));
                end
            end
            OP_FENCE: begin
                dec.opcode_type[OPC_FENCE] = 1'b1;
                dec.imm = imm_i;
            end
            default: illegal = 1'b1;
        endcase
        dec.alu_operation = m_op ? '0 : (`ALU_WIDTH'(1) << alu_sel);
        dec.mdu_op        = m_op ? (8'd1 << f3) : 8'd0;
        dec.exception     = {mret, ebreak, ecall, illegal};
    end

    payload_t             main_q, main_d;
    payload_t             skid_q, skid_d;
    logic                 main_valid_q, main_valid_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [CNT_WIDTH-1:0] dec_cnt_q, dec_cnt_d;
    logic [CNT_WIDTH-1:0] ill_cnt_q, ill_cnt_d;
    logic                 accept;
    logic                 consume;

    assign accept  = in_valid && !skid_valid_q && !flush;
    assign consume = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        dec_cnt_d    = dec_cnt_q;
        ill_cnt_d    = ill_cnt_q;
        if (consume) begin
            main_valid_d = 1'b0;
            dec_cnt_d    = dec_cnt_q + CNT_WIDTH'(1);
            if (main_q.exception[0]) ill_cnt_d = ill_cnt_q + CNT_WIDTH'(1);
        end
        // accept cannot coincide with a skid transfer: in_ready is low then
        if (consume && skid_valid_q && !flush) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
        end else if (accept) begin
            if (!main_valid_q || out_ready) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
        end
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            dec_cnt_q    <= '0;
            ill_cnt_q    <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            dec_cnt_q    <= dec_cnt_d;
            ill_cnt_q    <= ill_cnt_d;
        end
    end

    assign in_ready      = !skid_valid_q;
    assign out_valid     = main_valid_q;
    assign pc            = main_q.pc;
    assign rs1           = main_q.rs1;
    assign rs2           = main_q.rs2;
    assign rd            = main_q.rd;
    assign funct3        = main_q.funct3;
    assign imm           = main_q.imm;
    assign alu_operation = main_q.alu_operation;
    assign opcode_type   = main_q.opcode_type;
    assign mdu_op        = main_q.mdu_op;
    assign exception     = main_q.exception;
    assign decoded_cnt   = dec_cnt_q;
    assign illegal_cnt   = ill_cnt_q;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Bench for decode_stage_hs: M_EXT=1/32-bit counters and M_EXT=0/4-bit counters
// driven in parallel and checked against a queue-based reference model.
module tb_decode_stage_hs;

    localparam int A_ADD = 0, A_SUB = 1, A_SLT = 2, A_SLTU = 3, A_XOR = 4;
    localparam int A_OR = 5, A_AND = 6, A_SLL = 7, A_SRL = 8, A_SRA = 9;
    localparam int A_EQ = 10, A_NEQ = 11, A_GE = 12, A_GEU = 13;
    localparam int O_R = 0, O_I = 1, O_LD = 2, O_ST = 3, O_BR = 4, O_JAL = 5;
    localparam int O_JALR = 6, O_LUI = 7, O_AUIPC = 8, O_SYS = 9, O_FENCE = 10;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [13:0] alu;
        logic [10:0] opc;
        logic [7:0]  mdu;
        logic [3:0]  exc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic flush = 1'b0;
    logic out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;

    logic in_ready0, out_valid0, in_ready1, out_valid1;
    logic [31:0] pc0, imm0, pc1, imm1, dcnt0, icnt0;
    logic [4:0] rs1_0, rs2_0, rd_0, rs1_1, rs2_1, rd_1;
    logic [2:0] f3_0, f3_1;
    logic [13:0] alu0, alu1;
    logic [10:0] opc0, opc1;
    logic [7:0] mdu0, mdu1;
    logic [3:0] exc0, exc1, dcnt1, icnt1;
    exp_t act0, act1;

    assign act0 = {pc0, rs1_0, rs2_0, rd_0, f3_0, imm0, alu0, opc0, mdu0, exc0};
    assign act1 = {pc1, rs1_1, rs2_1, rd_1, f3_1, imm1, alu1, opc1, mdu1, exc1};

    decode_stage_hs #(.M_EXT(1'b1), .CNT_WIDTH(32)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .pc(pc0),
        .rs1(rs1_0), .rs2(rs2_0), .rd(rd_0), .funct3(f3_0), .imm(imm0),
        .alu_operation(alu0), .opcode_type(opc0), .mdu_op(mdu0),
        .exception(exc0), .decoded_cnt(dcnt0), .illegal_cnt(icnt0)
    );

    decode_stage_hs #(.M_EXT(1'b0), .CNT_WIDTH(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .pc(pc1),
        .rs1(rs1_1), .rs2(rs2_1), .rd(rd_1), .funct3(f3_1), .imm(imm1),
        .alu_operation(alu1), .opcode_type(opc1), .mdu_op(mdu1),
        .exception(exc1), .decoded_cnt(dcnt1), .illegal_cnt(icnt1)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [31:0] dec0, ill0;
    logic [3:0] dec1, ill1;

    function automatic int shift_alu(input logic [2:0] f, input logic alt);
        int a;
        case (f)
            3'd0: a = alt ? A_SUB : A_ADD;
            3'd1: a = A_SLL;
            3'd2: a = A_SLT;
            3'd3: a = A_SLTU;
            3'd4: a = A_XOR;
            3'd5: a = alt ? A_SRA : A_SRL;
            3'd6: a = A_OR;
            default: a = A_AND;
        endcase
        return a;
    endfunction

    function automatic exp_t ref_dec(input logic [31:0] i, input logic [31:0] p, input bit mext);
        exp_t e;
        bit ill, mop, ec, eb, mr;
        int a;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [11:0] s;
        logic [31:0] ii;
        e = '0;
        ill = 0; mop = 0; ec = 0; eb = 0; mr = 0;
        a = A_ADD;
        f3 = i[14:12];
        f7 = i[31:25];
        s = i[31:20];
        ii = {{20{i[31]}}, s};
        e.pc = p; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; e.f3 = f3;
        case (i[6:0])
            7'h33: begin
                e.opc[O_R] = 1'b1;
                mop = mext && (f7 == 7'h01);
                ill = !(f7 == 7'h00 || mop || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
                a = shift_alu(f3, i[30]);
            end
            7'h13: begin
                e.opc[O_I] = 1'b1; e.imm = ii;
                ill = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 inside {7'h00, 7'h20}));
                a = (f3 == 0) ? A_ADD : shift_alu(f3, i[30]);
            end
            7'h03: begin e.opc[O_LD] = 1'b1; e.imm = ii; ill = f3 inside {3, 6, 7}; end
            7'h23: begin
                e.opc[O_ST] = 1'b1; ill = f3 >= 3;
                e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
            end
            7'h63: begin
                e.opc[O_BR] = 1'b1;
                e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                ill = f3 inside {2, 3};
                case (f3)
                    3'd0: a = A_EQ;
                    3'd1: a = A_NEQ;
                    3'd4: a = A_SLT;
                    3'd5: a = A_GE;
                    3'd6: a = A_SLTU;
                    3'd7: a = A_GEU;
                    default: a = A_ADD;
                endcase
            end
            7'h6F: begin
                e.opc[O_JAL] = 1'b1;
                e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            7'h67: begin e.opc[O_JALR] = 1'b1; e.imm = ii; ill = f3 != 0; end
            7'h37: begin e.opc[O_LUI] = 1'b1; e.imm = {i[31:12], 12'd0}; end
            7'h17: begin e.opc[O_AUIPC] = 1'b1; e.imm = {i[31:12], 12'd0}; end
            7'h73: begin
                e.opc[O_SYS] = 1'b1; e.imm = {20'd0, s};
                ill = (f3 == 4) || (f3 == 0 && !(s inside {12'h000, 12'h001, 12'h302, 12'h105}));
                if (f3 == 0) begin ec = s == 12'h000; eb = s == 12'h001; mr = s == 12'h302; end
            end
            7'h0F: begin e.opc[O_FENCE] = 1'b1; e.imm = ii; end
            default: ill = 1;
        endcase
        e.alu = mop ? 14'd0 : (14'd1 << a);
        e.mdu = mop ? (8'd1 << f3) : 8'd0;
        e.exc = {mr, eb, ec, ill};
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        i = $urandom;
        case ($urandom_range(0, 13))
            0: i[6:0] = 7'h33;  1: i[6:0] = 7'h13;  2: i[6:0] = 7'h03;
            3: i[6:0] = 7'h23;  4: i[6:0] = 7'h63;  5: i[6:0] = 7'h6F;
            6: i[6:0] = 7'h67;  7: i[6:0] = 7'h37;  8: i[6:0] = 7'h17;
            9: i[6:0] = 7'h73; 10: i[6:0] = 7'h0F; 11: i[6:0] = 7'h33;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: i[31:25] = 7'h00;
            1: i[31:25] = 7'h20;
            2: i[31:25] = 7'h01;
            default: ;
        endcase
        if (i[6:0] == 7'h73 && $urandom_range(0, 1) == 1) begin
            i[14:12] = 3'd0;
            case ($urandom_range(0, 3))
                0: i[31:20] = 12'h000;
                1: i[31:20] = 12'h001;
                2: i[31:20] = 12'h302;
                default: i[31:20] = 12'h105;
            endcase
        end
        return i;
    endfunction

    // advance one clock, updating the reference buffer from the pre-edge inputs
    task automatic step();
        bit cons, acc;
        exp_t e0, e1;
        cons = (q0.size() > 0) && out_ready;
        acc = in_valid && (q0.size() < 2) && !flush;
        e0 = ref_dec(in_instr, in_pc, 1'b1);
        e1 = ref_dec(in_instr, in_pc, 1'b0);
        @(posedge clk);
        if (cons) begin
            dec0 += 1; dec1 += 1;
            if (q0[0].exc[0]) ill0 += 1;
            if (q1[0].exc[0]) ill1 += 1;
            void'(q0.pop_front());
            void'(q1.pop_front());
        end
        if (flush) begin
            q0.delete(); q1.delete();
        end else if (acc) begin
            q0.push_back(e0); q1.push_back(e1);
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        q0.delete(); q1.delete();
        dec0 = '0; ill0 = '0; dec1 = '0; ill1 = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
            errors++; $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid0, in_ready0);
        end
        vectors++;
        if (act0 !== '0) begin
            errors++; $display("FAIL reset_payload: got %h want 0", act0);
        end
        vectors++;
        if (dcnt0 !== 0 || icnt0 !== 0) begin
            errors++; $display("FAIL reset_cnt: dec=%0d ill=%0d want 0", dcnt0, icnt0);
        end
        rst = 1'b0;
        q0.delete(); q1.delete();
        dec0 = '0; ill0 = '0; dec1 = '0; ill1 = '0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [3];
        ins[0] = 32'h002081B3; ins[1] = 32'h402081B3; ins[2] = 32'h022081B3;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_instr = ins[k]; in_pc = 32'h100 + 32'(4 * k);
            step();
            vectors++;
            if (out_valid0 !== 1'b1 || pc0 !== 32'h100 + 32'(4 * k)) begin
                errors++; $display("FAIL b2b_latency[%0d]: valid=%b pc=%h", k, out_valid0, pc0);
            end
            vectors++;
            if (act0 !== q0[0]) begin
                errors++; $display("FAIL b2b_payload[%0d]: got %h want %h", k, act0, q0[0]);
            end
        end
        vectors++;
        if (mdu0 !== 8'h01 || alu0 !== 14'd0 || exc0 !== 4'd0) begin
            errors++; $display("FAIL mul_mext1: mdu=%h alu=%h exc=%h", mdu0, alu0, exc0);
        end
        vectors++;
        if (exc1 !== 4'b0001 || mdu1 !== 8'h00) begin
            errors++; $display("FAIL mul_mext0: exc=%b mdu=%h want 0001/00", exc1, mdu1);
        end
        in_valid = 1'b0;
        step();
        vectors++;
        if (dcnt0 !== 32'd3 || out_valid0 !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: cnt=%0d valid=%b want 3/0", dcnt0, out_valid0);
        end
    endtask

    task automatic test_alu_onehot();
        out_ready = 1'b1; in_valid = 1'b1;
        in_instr = 32'h002081B3; in_pc = 32'h180;
        step();
        vectors++;
        if (alu0 !== 14'd1 << A_ADD || opc0 !== 11'd1 << O_R) begin
            errors++; $display("FAIL add_onehot: alu=%h opc=%h", alu0, opc0);
        end
        in_instr = 32'h402081B3;
        step();
        vectors++;
        if (alu0 !== 14'd1 << A_SUB) begin
            errors++; $display("FAIL sub_onehot: alu=%h want %h", alu0, 14'd1 << A_SUB);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_imm();
        out_ready = 1'b1; in_valid = 1'b1;
        in_instr = 32'hFFF00093; in_pc = 32'h200;
        step();
        vectors++;
        if (imm0 !== 32'hFFFFFFFF || rd_0 !== 5'd1 || opc0 !== 11'd1 << O_I || alu0 !== 14'd1 << A_ADD) begin
            errors++; $display("FAIL addi: imm=%h rd=%0d opc=%h alu=%h", imm0, rd_0, opc0, alu0);
        end
        in_instr = 32'hFE000EE3; in_pc = 32'h204;
        step();
        vectors++;
        if (imm0 !== 32'hFFFFFFFC || alu0 !== 14'd1 << A_EQ || opc0 !== 11'd1 << O_BR) begin
            errors++; $display("FAIL beq: imm=%h alu=%h opc=%h", imm0, alu0, opc0);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_system();
        logic [31:0] ins [3];
        logic [3:0] want [3];
        logic [31:0] ic;
        ins[0] = 32'h00000073; ins[1] = 32'h00100073; ins[2] = 32'h30200073;
        want[0] = 4'b0010; want[1] = 4'b0100; want[2] = 4'b1000;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_instr = ins[k]; in_pc = 32'h300 + 32'(4 * k);
            step();
            vectors++;
            if (exc0 !== want[k]) begin
                errors++; $display("FAIL sys_exc[%0d]: got %b want %b", k, exc0, want[k]);
            end
        end
        ic = icnt0;
        in_instr = 32'h40209093;
        step();
        vectors++;
        if (exc0 !== 4'b0001) begin
            errors++; $display("FAIL slli_illegal: got %b want 0001", exc0);
        end
        in_valid = 1'b0;
        step();
        vectors++;
        if (icnt0 !== ic + 32'd1) begin
            errors++; $display("FAIL illegal_cnt: got %0d want %0d", icnt0, ic + 32'd1);
        end
    endtask

    task automatic test_stall();
        int idx, n;
        bit fire;
        apply_reset();
        idx = 0; n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            out_ready = !(c >= 1 && c <= 3);
            in_valid = (idx < 4);
            in_instr = 32'h00000093 | (32'(idx) << 20);
            in_pc = 32'h400 + 32'(4 * idx);
            if (c == 2) begin
                vectors++;
                if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1) begin
                    errors++; $display("FAIL stall_full: in_ready=%b out_valid=%b want 0/1", in_ready0, out_valid0);
                end
            end
            if (out_valid0 && out_ready) begin
                vectors++;
                if (pc0 !== 32'h400 + 32'(4 * n)) begin
                    errors++; $display("FAIL stall_order[%0d]: pc=%h want %h", n, pc0, 32'h400 + 32'(4 * n));
                end
                n++;
            end
            fire = in_valid && in_ready0;
            step();
            if (fire) idx++;
        end
        in_valid = 1'b0;
        vectors++;
        if (n !== 4 || dcnt0 !== 32'd4 || out_valid0 !== 1'b0) begin
            errors++; $display("FAIL stall_delivered: n=%0d cnt=%0d valid=%b want 4/4/0", n, dcnt0, out_valid0);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'h500;
        step();
        in_pc = 32'h504;
        step();
        vectors++;
        if (in_ready0 !== 1'b0) begin
            errors++; $display("FAIL flush_prefill: in_ready=%b want 0", in_ready0);
        end
        in_pc = 32'h508; flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        vectors++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || dcnt0 !== 32'd1) begin
            errors++; $display("FAIL flush_clear: valid=%b ready=%b cnt=%0d want 0/1/1", out_valid0, in_ready0, dcnt0);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            vectors++;
            if (out_valid0 !== 1'b0) begin
                errors++; $display("FAIL flush_ghost[%0d]: out_valid=%b pc=%h", k, out_valid0, pc0);
            end
        end
    endtask

    task automatic test_random();
        logic ev;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            ev = (q0.size() > 0);
            vectors++;
            if (out_valid0 !== ev || out_valid1 !== ev) begin
                errors++; $display("FAIL rnd_valid@%0d: got %b/%b want %b", c, out_valid0, out_valid1, ev);
            end
            vectors++;
            if (in_ready0 !== (q0.size() < 2) || in_ready1 !== (q0.size() < 2)) begin
                errors++; $display("FAIL rnd_ready@%0d: got %b/%b held=%0d", c, in_ready0, in_ready1, q0.size());
            end
            if (ev) begin
                vectors++;
                if (act0 !== q0[0]) begin
                    errors++; $display("FAIL rnd_payload0@%0d: got %h want %h", c, act0, q0[0]);
                end
                vectors++;
                if (act1 !== q1[0]) begin
                    errors++; $display("FAIL rnd_payload1@%0d: got %h want %h", c, act1, q1[0]);
                end
            end
            vectors++;
            if (dcnt0 !== dec0 || icnt0 !== ill0 || dcnt1 !== dec1 || icnt1 !== ill1) begin
                errors++; $display("FAIL rnd_cnt@%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                    c, dcnt0, icnt0, dcnt1, icnt1, dec0, ill0, dec1, ill1);
            end
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 29) == 0);
            in_instr = rand_instr();
            in_pc = $urandom;
            step();
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'h600;
        repeat (3) step();
        out_ready = 1'b0;
        repeat (2) step();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || act0 !== '0) begin
            errors++; $display("FAIL async_reset_out: valid=%b ready=%b payload=%h", out_valid0, in_ready0, act0);
        end
        vectors++;
        if (dcnt0 !== 0 || icnt0 !== 0) begin
            errors++; $display("FAIL async_reset_cnt: dec=%0d ill=%0d want 0", dcnt0, icnt0);
        end
        apply_reset();
        step();
        vectors++;
        if (out_valid0 !== 1'b0 || dcnt0 !== 0) begin
            errors++; $display("FAIL reset_drop: valid=%b cnt=%0d want 0/0", out_valid0, dcnt0);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h700;
        repeat (16) step();
        vectors++;
        if (dcnt1 !== 4'd15) begin
            errors++; $display("FAIL wrap_pre: cnt=%0d want 15", dcnt1);
        end
        step();
        vectors++;
        if (dcnt1 !== 4'd0 || dcnt0 !== 32'd16) begin
            errors++; $display("FAIL wrap: cnt4=%0d cnt32=%0d want 0/16", dcnt1, dcnt0);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_alu_onehot();
        test_imm();
        test_system();
        test_stall();
        test_flush();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage_hs.md
# decode_stage_hs

Parametrised RV32 decode stage with a valid/ready handshake in place of the clk_en/stall chain. It sits between fetch and execute, and decodes one 32-bit instruction per cycle into registered ALU/opcode/immediate/exception fields. It optionally decodes the M extension and applies strict funct7/funct3 legality checks. A 2-entry output buffer (main + skid) gives full throughput under back-pressure without a combinational ready path from execute to fetch.

## Interface
- M_EXT, 1: 1 = decode MUL/DIV group into mdu_op; 0 = funct7 0000001 is illegal.
- CNT_WIDTH, 32: width of the decoded/illegal instruction counters.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  32  PC of in_instr.
- flush  in  1  discard all held and incoming instructions.
- out_valid  out  1  decoded payload valid.
- out_ready  in  1  execute consumes payload this cycle.
- pc  out  32  PC of the payload.
- rs1, rs2, rd  out  5 each  register addresses.
- funct3  out  3  instr[14:12].
- imm  out  32  extended immediate.
- alu_operation  out  `ALU_WIDTH  one-hot ALU op.
- opcode_type  out  `OPCODE_WIDTH  one-hot opcode class.
- mdu_op  out  8  one-hot, bit index = funct3 (MUL..REMU); all zero when M_EXT=0.
- exception  out  `EXCEPTION_WIDTH  ILLEGAL/ECALL/EBREAK/MRET.
- decoded_cnt  out  CNT_WIDTH  payloads handed to execute.
- illegal_cnt  out  CNT_WIDTH  handed-over payloads with ILLEGAL set.

## Operation
- Decode is combinational from in_instr. Its results are registered into the main entry, or into the skid entry when the main entry is held.
- ALU/opcode/immediate decode:
  - Same one-hot ALU/opcode encodings and immediate formats (I/S/B/J/U/X) as the existing decoder.
  - Non-R/I/branch classes select ADD.
  - M-ops (R-type, funct7 0000001, M_EXT=1) set mdu_op[funct3] with alu_operation all zero.
- ILLEGAL is set when any of the following holds:
  - instr[1:0] != 11, or the opcode is unknown.
  - R-type funct7 is not in {0000000; 0100000 with funct3 000/101; 0000001 with M_EXT}.
  - SLLI funct7 != 0, or SRLI/SRAI funct7 not in {0000000, 0100000}.
  - Branch funct3 is 010/011.
  - Load funct3 is 011/110/111.
  - Store funct3 >= 011.
  - JALR funct3 != 000.
  - SYSTEM funct3 is 100.
  - SYSTEM funct3 000 with instr[31:20] not in {000, 001, 302, 105}.
- ECALL/EBREAK/MRET are set for SYSTEM funct3 000 with instr[31:20] = 000 / 001 / 302 respectively. 105 (WFI) decodes as legal with no exception bit.
- Buffer:
  - in_ready = !skid_valid.
  - Accept = in_valid && in_ready && !flush.
  - Accept while main is empty or being consumed (out_ready): load main.
  - Accept while main is held: load skid.
  - Main consumed while skid is valid: skid moves to main, skid is cleared.
  - out_valid = main_valid.
- Flush: clears main_valid and skid_valid at the next edge. A same-cycle in_valid is dropped and a same-cycle out_ready handshake is still counted. Flush has priority over accept.
- Counters increment on out_valid && out_ready. They wrap modulo 2^CNT_WIDTH.
- Payload registers load only on accept or skid transfer. They hold their value otherwise, including on flush.

## Timing
- Latency: in_valid accepted at edge N gives out_valid at edge N (registered); the payload is visible in cycle N+1.
- Throughput: 1 instruction/cycle while out_ready=1.
- Under stall, at most 2 instructions are held. in_ready falls the cycle after the skid entry fills and rises the cycle after it drains.
- No combinational path from out_ready to in_ready.
- Reset (async assert, sync-released internal state): out_valid=0, skid empty, in_ready=1, all payload outputs 0, counters 0.
- Reset mid-transfer drops both entries with no handshake.
- Simultaneous skid transfer + new accept is impossible because in_ready=0 while the skid is valid.

## Test plan
- ADD 0x002081B3, SUB 0x402081B3, MUL 0x022081B3 back-to-back with out_ready=1:
  - Payloads one cycle after each accept.
  - ADD, SUB one-hot respectively.
  - MUL gives mdu_op=00000001 with M_EXT=1, ILLEGAL with M_EXT=0.
- ADDI 0xFFF00093 -> imm=0xFFFFFFFF, rd=1, ITYPE, ADD. BEQ 0xFE000EE3 -> imm=0xFFFFFFFC, EQ, BRANCH.
- ECALL 0x00000073, EBREAK 0x00100073, MRET 0x30200073 -> respective exception bit only. 0x40209093 (SLLI funct7≠0) -> ILLEGAL, illegal_cnt +1.
- Stream 4 instructions with out_ready low for 3 cycles after the first:
  - Main and skid fill, in_ready=0.
  - On release, all 4 are delivered in order with no loss or duplication, and decoded_cnt=4.
- Flush with main+skid full and in_valid=1: next cycle out_valid=0, in_ready=1, and none of the 3 instructions appears later.
- Assert rst mid-stream -> outputs/counters 0 immediately (async). Preload the counters to max with a reduced CNT_WIDTH=4: the 16th handshake wraps the count to 0.
